gf_mul_digit_serial: RTL and testbench
======================================

// Module: gf_mul_digit_serial
// PURPOSE
//  Parametrised digit-serial multiplier in GF(2^WIDTH), polynomial basis, reducing modulo a
//  configurable irreducible polynomial. Generalises the fixed GF(2^2)/GF(2^4) combinational
//  multipliers of the tower-field S-box path to any field width. It processes DIGIT bits of A
//  per cycle, trading latency for area. Used by MixColumns/key-schedule experiments and as a
//  reference GF(2^8) multiplier for S-box cross-checking. Valid/ready on both sides.
// PARAMETERS
//  WIDTH  8      field degree m; operand/result width; >= 2
//  DIGIT  2      A bits consumed per cycle; 1..WIDTH; WIDTH % DIGIT == 0 (elaboration error otherwise)
//  POLY   8'h1B  low WIDTH bits of the irreducible P(x); x^WIDTH term implied (AES: x^8+x^4+x^3+x+1)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      operands presented
//  in_ready   out  1      block can accept operands (IDLE only)
//  in_a       in   WIDTH  multiplicand A, consumed MSB digit first
//  in_b       in   WIDTH  multiplier B, held in a register for the whole operation
//  out_valid  out  1      out_q holds A*B mod P
//  out_ready  in   1      consumer accepts out_q
//  out_q      out  WIDTH  product
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low (rst_n sampled on rising edge of clk).
//  - Reset: state=IDLE, in_ready=1, out_valid=0, out_q=0, acc/a_sh/b_reg/cnt=0.
//  - NCYC = WIDTH/DIGIT. FSM states IDLE, BUSY, DONE.
//  - IDLE: in_ready=1. in_valid=1 -> latch a_sh<=in_a, b_reg<=in_b, acc<=0, cnt<=0; go BUSY.
//  - BUSY: in_ready=0. Each cycle
//      acc <= (acc * x^DIGIT mod P) ^ (a_sh[WIDTH-1 -: DIGIT] * b_reg mod P);
//      a_sh <= a_sh << DIGIT; cnt <= cnt+1.
//    After the cycle with cnt==NCYC-1 -> DONE; out_q <= the new acc value.
//  - Latency: out_valid rises exactly NCYC cycles after the accepting edge (4 for 8/2, 8 for 8/1).
//  - DONE: out_valid=1, out_q stable, in_ready=0. out_ready=1 -> IDLE next cycle (out_valid=0).
//    No same-cycle drain+accept; minimum initiation interval is NCYC+2 cycles.
//    out_ready is ignored outside DONE; in_valid is ignored outside IDLE. in_a/in_b may change
//    after acceptance without effect.
//  - Arithmetic: pure XOR/AND, no carries. Reduction per bit: if bit WIDTH is set, XOR POLY and drop
//    that bit. All intermediates WIDTH bits after reduction.
//  - Operand 0 -> result 0; B=1 -> result A; result always < 2^WIDTH.
//  - rst_n low mid-BUSY or in DONE: operation is discarded, no out_valid pulse, reset values next cycle.
//  - POLY is not checked for irreducibility; a reducible POLY yields ring products (documented, not an error).
// STRUCTURE
//  - Shared package gf_pkg: localparam AES_POLY=8'h1B, GF16_POLY=4'h3, GF4_POLY=2'h3;
//    function gf_ncyc(width,digit); FSM state enum typedef (IDLE/BUSY/DONE).
//  - Sub-module gf_digit_step (combinational, params WIDTH/DIGIT/POLY): inputs acc, digit, b;
//    output next acc. Holds the x^DIGIT shift-reduce and the digit*B partial-product XOR tree.
//  - Top holds the FSM, cnt ($clog2(NCYC+1) bits), a_sh, b_reg, acc, out_q registers.
// TESTING
//  1. W=8,D=2,AES: A=0x57,B=0x83 -> out_q=0xC1, out_valid 4 cycles after accept.
//  2. W=8,D=1: A=0x57,B=0x13 -> 0xFE after 8 cycles; A=0x00,B=0xFF -> 0x00; A=0xA5,B=0x01 -> 0xA5.
//  3. W=4,D=4,POLY=4'h3: A=0x7,B=0x9 -> 0xA, latency 1 cycle.
//  4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_q steady, in_ready=0,
//     in_valid pulses ignored. Release -> next operand accepted 2 cycles later.
//  5. Reset mid-op: rst_n=0 at BUSY cnt=1 -> next cycle IDLE, out_valid never asserts,
//     out_q=0. The following op A=0x02,B=0x80 -> 0x1B.
//  6. Random: 10k ops per (W,D) in {(8,1),(8,2),(8,4),(8,8),(4,2)} vs. a reference model;
//     the 8-bit result must match the S-box inverse check (A*inv(A)=1 for A!=0).

Source files
------------

// File: rtl/gf_pkg.sv
// gf_pkg: shared GF(2^m) constants, digit-serial cycle count helper and multiplier FSM state type
package gf_pkg;
  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam logic [3:0] GF16_POLY = 4'h3;
  localparam logic [1:0] GF4_POLY = 2'h3;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int gf_ncyc(input int width, input int digit);
    return width / digit;
  endfunction
endpackage

// File: rtl/gf_digit_step.sv
// gf_digit_step: combinational acc*x^DIGIT + digit*b mod P (ports: acc, digit, b in; nxt out), Horner over digit bits MSB first
module gf_digit_step #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(8'h1B)
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [DIGIT-1:0] digit,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] nxt
);
  function automatic logic [WIDTH-1:0] xt(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
  endfunction
  always_comb begin
    nxt = acc;
    for (int i = DIGIT - 1; i >= 0; i--) nxt = xt(nxt) ^ (digit[i] ? b : '0);
  end
endmodule

// File: rtl/gf_mul_digit_serial.sv
// gf_mul_digit_serial: digit-serial GF(2^WIDTH) multiplier, valid/ready in (in_valid/in_ready/in_a/in_b) and out (out_valid/out_ready/out_q), clk, sync active-low rst_n
module gf_mul_digit_serial
  import gf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(AES_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q
);
  localparam int NCYC = gf_ncyc(WIDTH, DIGIT);
  localparam int CW = $clog2(NCYC + 1);
  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad
    $error("gf_mul_digit_serial: illegal WIDTH/DIGIT");
  end
  state_t state, state_nxt;
  logic [WIDTH-1:0] acc, a_sh, b_reg, step;
  logic [CW-1:0] cnt;
  logic last;
  gf_digit_step #(.WIDTH(WIDTH), .DIGIT(DIGIT), .POLY(POLY)) u_step (
    .acc(acc),
    .digit(a_sh[WIDTH-1 -: DIGIT]),
    .b(b_reg),
    .nxt(step)
  );
  assign last = cnt == CW'(NCYC - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_nxt = state == IDLE ? (in_valid ? BUSY : IDLE) :
                state == BUSY ? (last ? DONE : BUSY) :
                (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      a_sh <= '0;
      b_reg <= '0;
      cnt <= '0;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        a_sh <= in_a;
        b_reg <= in_b;
        acc <= '0;
        cnt <= '0;
      end
      if (state == BUSY) begin
        acc <= step;
        a_sh <= a_sh << DIGIT;
        cnt <= cnt + 1'b1;
        if (last) out_q <= step;
      end
    end
  end
endmodule

// File: tb/tb_gf_mul_digit_serial.sv
// tb_gf_mul_digit_serial: checks six multiplier configurations against a long-division GF reference model
module tb_gf_mul_digit_serial;
  localparam int N = 6;
  localparam int WS[N] = '{8, 8, 8, 8, 4, 4};
  localparam int DS[N] = '{2, 1, 4, 8, 2, 4};
  localparam int PS[N] = '{27, 27, 27, 27, 3, 3};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iv[N];
  logic ordy[N];
  logic [7:0] ai[N];
  logic [7:0] bi[N];
  logic ir[N];
  logic ov[N];
  logic [7:0] qo[N];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = WS[g];
    logic r, v;
    logic [W-1:0] q;
    gf_mul_digit_serial #(.WIDTH(W), .DIGIT(DS[g]), .POLY(W'(PS[g]))) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(iv[g]),
      .in_ready(r),
      .in_a(ai[g][W-1:0]),
      .in_b(bi[g][W-1:0]),
      .out_valid(v),
      .out_ready(ordy[g]),
      .out_q(q)
    );
    assign ir[g] = r;
    assign ov[g] = v;
    assign qo[g] = 8'(q);
  end
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input int k);
    logic [15:0] prod, m;
    int w;
    w = WS[k];
    prod = '0;
    for (int i = 0; i < w; i++) if (a[i]) prod ^= 16'(b) << i;
    m = 16'(PS[k]) | (16'd1 << w);
    for (int i = 2 * w - 2; i >= w; i--) if (prod[i]) prod ^= m << (i - w);
    return prod[7:0];
  endfunction
  function automatic logic [7:0] mask(input int k, input logic [7:0] v);
    return WS[k] == 8 ? v : (v & 8'h0F);
  endfunction
  task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b, input int hold,
                        output logic [7:0] q, output int lat);
    iv[k] = 1'b1;
    ai[k] = a;
    bi[k] = b;
    ordy[k] = 1'b0;
    @(negedge clk);
    iv[k] = 1'b0;
    ai[k] = 8'($urandom);
    bi[k] = 8'($urandom);
    lat = 0;
    while (!ov[k]) begin
      if (lat > 40) begin
        lat = -1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    q = qo[k];
    repeat (hold) @(negedge clk);
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks += 3;
      if (ir[k] !== 1'b1) begin failures++; $display("FAIL reset_in_ready dut%0d got=%b exp=1", k, ir[k]); end
      if (ov[k] !== 1'b0) begin failures++; $display("FAIL reset_out_valid dut%0d got=%b exp=0", k, ov[k]); end
      if (qo[k] !== 8'h00) begin failures++; $display("FAIL reset_out_q dut%0d got=%h exp=00", k, qo[k]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_vectors();
    int vk[6] = '{0, 1, 1, 1, 5, 0};
    logic [7:0] va[6] = '{8'h57, 8'h57, 8'h00, 8'hA5, 8'h07, 8'h02};
    logic [7:0] vb[6] = '{8'h83, 8'h13, 8'hFF, 8'h01, 8'h09, 8'h80};
    logic [7:0] vq[6] = '{8'hC1, 8'hFE, 8'h00, 8'hA5, 8'h0A, 8'h1B};
    int vl[6] = '{4, 8, 8, 8, 1, 4};
    logic [7:0] q;
    int lat;
    for (int i = 0; i < 6; i++) begin
      checks += 3;
      if (ir[vk[i]] !== 1'b1) begin failures++; $display("FAIL vec%0d_ready got=%b exp=1", i, ir[vk[i]]); end
      run_op(vk[i], va[i], vb[i], 0, q, lat);
      if (q !== vq[i]) begin failures++; $display("FAIL vec%0d_product got=%h exp=%h", i, q, vq[i]); end
      if (lat != vl[i]) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, vl[i]); end
    end
  endtask
  task automatic test_backpressure();
    logic [7:0] a, b, e, q;
    int lat;
    a = 8'($urandom_range(1, 255));
    b = 8'($urandom_range(1, 255));
    e = ref_mul(a, b, 0);
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    ai[0] = a;
    bi[0] = b;
    @(negedge clk);
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    for (int i = 0; i < 10; i++) begin
      iv[0] = i[0];
      ai[0] = ~a;
      bi[0] = ~b;
      @(negedge clk);
      checks += 3;
      if (qo[0] !== e) begin failures++; $display("FAIL bp_hold_q cyc%0d got=%h exp=%h", i, qo[0], e); end
      if (ir[0] !== 1'b0) begin failures++; $display("FAIL bp_hold_ready cyc%0d got=%b exp=0", i, ir[0]); end
      if (ov[0] !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc%0d got=%b exp=1", i, ov[0]); end
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    checks += 2;
    if (ov[0] !== 1'b0) begin failures++; $display("FAIL bp_drain_valid got=%b exp=0", ov[0]); end
    if (ir[0] !== 1'b1) begin failures++; $display("FAIL bp_drain_ready got=%b exp=1", ir[0]); end
    run_op(0, b, a, 0, q, lat);
    checks += 2;
    if (q !== e) begin failures++; $display("FAIL bp_next_product got=%h exp=%h", q, e); end
    if (lat != 4) begin failures++; $display("FAIL bp_next_latency got=%0d exp=4", lat); end
  endtask
  task automatic test_reset_mid_op();
    logic [7:0] q;
    int lat, seen;
    iv[0] = 1'b1;
    ai[0] = 8'h57;
    bi[0] = 8'h83;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks += 3;
    if (ir[0] !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", ir[0]); end
    if (ov[0] !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", ov[0]); end
    if (qo[0] !== 8'h00) begin failures++; $display("FAIL rst_mid_q got=%h exp=00", qo[0]); end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov[0] !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL rst_mid_no_valid got=%0d exp=0", seen); end
    run_op(0, 8'h02, 8'h80, 0, q, lat);
    checks++;
    if (q !== 8'h1B) begin failures++; $display("FAIL rst_mid_after got=%h exp=1b", q); end
  endtask
  task automatic test_random();
    logic [7:0] a, b, q, e;
    int lat, bad_q, bad_l;
    for (int k = 0; k < N; k++) begin
      bad_q = 0;
      bad_l = 0;
      for (int n = 0; n < 250; n++) begin
        a = mask(k, 8'($urandom));
        b = mask(k, 8'($urandom));
        e = ref_mul(a, b, k);
        run_op(k, a, b, $urandom_range(0, 2), q, lat);
        if (q !== e) begin
          bad_q++;
          if (bad_q < 4) $display("FAIL rand_product dut%0d a=%h b=%h got=%h exp=%h", k, a, b, q, e);
        end
        if (lat != WS[k] / DS[k]) begin
          bad_l++;
          if (bad_l < 4) $display("FAIL rand_latency dut%0d got=%0d exp=%0d", k, lat, WS[k] / DS[k]);
        end
      end
      checks += 2;
      if (bad_q != 0) failures++;
      if (bad_l != 0) failures++;
    end
  endtask
  task automatic test_inverse();
    logic [7:0] inv, q;
    int lat, bad;
    bad = 0;
    for (int a = 1; a < 256; a++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) if (ref_mul(8'(a), 8'(c), 0) == 8'h01) inv = 8'(c);
      run_op(0, 8'(a), inv, 0, q, lat);
      if (q !== 8'h01) begin
        bad++;
        if (bad < 4) $display("FAIL inverse a=%h inv=%h got=%h exp=01", a, inv, q);
      end
    end
    checks++;
    if (bad != 0) failures++;
  endtask
  initial begin
    for (int k = 0; k < N; k++) begin
      iv[k] = 1'b0;
      ordy[k] = 1'b0;
      ai[k] = '0;
      bi[k] = '0;
    end
    @(negedge clk);
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    test_inverse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
